// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider (div_iter, div_step).
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 32;

  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, trial subtract, restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One guard bit above the partial remainder makes the borrow show up as the sign.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {2'b00, dvs};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider, one quotient bit per cycle with valid/ready handshakes.
// Optional macro DIV_ITER_EARLY_EXIT_EN: finish after one CALC cycle when y==0 or |x|<|y|.
//
// state   | meaning
// IDLE    | in_ready high, waiting for a request
// CALC    | one quotient bit per cycle, counter counts down from WIDTH
// DONE    | result registered on entry, out_valid follows one edge later, held until out_ready
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             early;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] rem_raw;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // On the first CALC cycle quo_q still holds |x| untouched, so it can be compared directly.
`ifdef DIV_ITER_EARLY_EXIT_EN
  assign early = (cnt_q == CW'(WIDTH)) && ((dvs_q == '0) || (quo_q < dvs_q));
`else
  assign early = 1'b0;
`endif

  assign q_raw   = early ? '0 : {quo_q[WIDTH-2:0], step_q};
  assign rem_raw = early ? quo_q : step_rem[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    s_d         = s_q;
    r_d         = r_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            state_d    = ST_CALC;
            in_ready_d = 1'b0;
            cnt_d      = CW'(WIDTH);
            rem_d      = '0;
            quo_d      = (div_signed && x[WIDTH-1]) ? -x : x;
            dvs_d      = (div_signed && y[WIDTH-1]) ? -y : y;
            q_neg_d    = div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
            r_neg_d    = div_signed && x[WIDTH-1];
          end
        end
        ST_CALC: begin
          quo_d = {quo_q[WIDTH-2:0], step_q};
          rem_d = step_rem;
          cnt_d = cnt_q - CW'(1);
          if (early || (cnt_q == CW'(1))) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            dbz_d   = (dvs_q == '0);
            s_d     = (dvs_q == '0) ? '1 : (q_neg_q ? -q_raw : q_raw);
            r_d     = r_neg_q ? -rem_raw : rem_raw;
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      s_q         <= '0;
      r_q         <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      s_q         <= s_d;
      r_q         <= r_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign s           = s_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: WIDTH=32 directed cases and WIDTH=8 random sweep
// against a plain-arithmetic reference model.
module tb_div_iter;

`ifdef DIV_ITER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        iv32, iv8;
  logic        rdy32, rdy8;
  logic        sg;
  logic [31:0] xv, yv;
  logic        flush, ordy;
  logic        ov32, ov8;
  logic [31:0] s32, r32;
  logic [7:0]  s8, r8;
  logic        dz32, dz8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) u_div32 (
    .div_clk(clk), .resetn(resetn), .in_valid(iv32), .in_ready(rdy32),
    .div_signed(sg), .x(xv), .y(yv), .flush(flush),
    .out_valid(ov32), .out_ready(ordy), .s(s32), .r(r32), .div_by_zero(dz32)
  );

  div_iter #(.WIDTH(8)) u_div8 (
    .div_clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(rdy8),
    .div_signed(sg), .x(xv[7:0]), .y(yv[7:0]), .flush(flush),
    .out_valid(ov8), .out_ready(ordy), .s(s8), .r(r8), .div_by_zero(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on sign-extended integers, y==0 handled by rule.
  function automatic void model(input int w, input logic [31:0] xa, input logic [31:0] ya,
                                input bit sgn, output logic [31:0] es, output logic [31:0] er,
                                output bit edz, output int elat);
    longint mask, xs, ys, q, rm, ax, ay;
    mask = (longint'(1) << w) - 1;
    xs = longint'({32'b0, xa}) & mask;
    ys = longint'({32'b0, ya}) & mask;
    if (sgn && xs[w-1]) xs = xs - (longint'(1) << w);
    if (sgn && ys[w-1]) ys = ys - (longint'(1) << w);
    ax = (xs < 0) ? -xs : xs;
    ay = (ys < 0) ? -ys : ys;
    elat = w + 1;
    if (EARLY && ((ys == 0) || (ax < ay))) elat = 2;
    if (ys == 0) begin
      es  = 32'(mask);
      er  = 32'(longint'({32'b0, xa}) & mask);
      edz = 1'b1;
    end else begin
      q   = xs / ys;
      rm  = xs % ys;
      es  = 32'(q & mask);
      er  = 32'(rm & mask);
      edz = 1'b0;
    end
  endfunction

  task automatic issue(input bit w8, input logic [31:0] xa, input logic [31:0] ya,
                       input bit sgn, output int waited);
    waited = 0;
    @(negedge clk);
    sg = sgn; xv = xa; yv = ya;
    if (w8) iv8 = 1'b1; else iv32 = 1'b1;
    while (!(w8 ? rdy8 : rdy32) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_accept", w8 ? rdy8 : rdy32, 1);
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    xv = $urandom; yv = $urandom; sg = 1'($urandom);
    chk("ready_drops_on_accept", w8 ? rdy8 : rdy32, 0);
  endtask

  task automatic collect(input bit w8, input logic [31:0] xa, input logic [31:0] ya,
                         input bit sgn, input string tag);
    logic [31:0] es, er;
    bit edz;
    int elat, lat;
    model(w8 ? 8 : 32, xa, ya, sgn, es, er, edz, elat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(w8 ? ov8 : ov32) && lat < 200);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_s"}, w8 ? {24'b0, s8} : s32, es);
    chk({tag, "_r"}, w8 ? {24'b0, r8} : r32, er);
    chk({tag, "_dbz"}, w8 ? dz8 : dz32, edz);
  endtask

  task automatic release_out(input bit w8);
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("release_out_valid_low", w8 ? ov8 : ov32, 0);
    chk("release_in_ready_high", w8 ? rdy8 : rdy32, 1);
  endtask

  task automatic op(input bit w8, input logic [31:0] xa, input logic [31:0] ya,
                    input bit sgn, input string tag);
    int waited;
    issue(w8, xa, ya, sgn, waited);
    collect(w8, xa, ya, sgn, tag);
    release_out(w8);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] hs, hr, xa, ya;
    bit sgn, seen;
    int waited;

    resetn = 1'b0; iv32 = 1'b0; iv8 = 1'b0; flush = 1'b0; ordy = 1'b0;
    sg = 1'b0; xv = '0; yv = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready32", rdy32, 0);
    chk("rst_in_ready8", rdy8, 0);
    chk("rst_out_valid", ov32, 0);
    chk("rst_s", s32, 0);
    chk("rst_r", r32, 0);
    chk("rst_dbz", dz32, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready32", rdy32, 1);
    chk("post_rst_in_ready8", rdy8, 1);

    op(0, 32'd100, 32'd7, 0, "u100_7");
    op(0, 32'hFFFF_FFF9, 32'd2, 1, "s_m7_2");
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, "s_minneg_m1");
    op(0, 32'h0000_1234, 32'd0, 0, "u_div0");
    op(0, 32'hFFFF_1234, 32'd0, 1, "s_div0");
    op(0, 32'd5, 32'd9, 0, "u_small");

    // Back-pressure: result held while out_ready stays low.
    issue(0, 32'hFFFF_FC18, 32'd33, 1, waited);
    collect(0, 32'hFFFF_FC18, 32'd33, 1, "bp");
    hs = s32; hr = r32;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_s_stable", s32, hs);
      chk("bp_r_stable", r32, hr);
      chk("bp_in_ready_low", rdy32, 0);
      chk("bp_out_valid_high", ov32, 1);
    end
    release_out(0);
    issue(0, 32'd55, 32'd5, 0, waited);
    chk("bp_accept_next_edge", waited, 0);
    collect(0, 32'd55, 32'd5, 0, "bp_next");
    release_out(0);

    // Flush in the tenth CALC cycle with a request offered.
    issue(0, 32'd100, 32'd7, 0, waited);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; iv32 = 1'b1; xv = 32'd3; yv = 32'd1;
    @(posedge clk); #1;
    chk("flush_out_valid", ov32, 0);
    chk("flush_back_to_idle", rdy32, 1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("flush_priority_no_accept", rdy32, 1);
    flush = 1'b0; iv32 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) seen = 1'b1;
    end
    chk("flush_no_result", seen, 0);
    op(0, 32'd1000, 32'd10, 0, "after_flush");

    for (int i = 0; i < 8; i++) begin
      xa = $urandom; ya = $urandom >> $urandom_range(0, 31); sgn = 1'($urandom);
      op(0, xa, ya, sgn, "rand32");
    end

    for (int i = 0; i < 48; i++) begin
      xa = {24'b0, 8'($urandom)};
      ya = {24'b0, 8'($urandom)};
      sgn = 1'($urandom);
      case (i % 8)
        0: ya = 32'd0;
        1: begin xa = 32'h80; ya = 32'hFF; sgn = 1'b1; end
        2: ya = {29'b0, 3'($urandom)};
        3: xa = {28'b0, 4'($urandom)};
        default: ;
      endcase
      op(1, xa, ya, sgn, "rand8");
    end

    // Reset pulse in the middle of CALC: the operation is abandoned.
    issue(1, 32'd200, 32'd3, 0, waited);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_in_ready", rdy8, 0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    chk("midrst_idle", rdy8, 1);
    op(1, 32'hF6, 32'h03, 1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 32, operand/result width (legal 8..64, even).
REQ-002 SHALL provide port: div_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide ports: in_valid  input  1  request offered; in_ready  output  1  request acceptable.
REQ-005 SHALL provide ports: div_signed  input  1  two's-complement mode; x  input  WIDTH  dividend; y  input  WIDTH  divisor.
REQ-006 SHALL provide port: flush  input  1  synchronous abort of any in-flight or held operation.
REQ-007 SHALL provide ports: out_valid  output  1  result held; out_ready  input  1  consumer takes result.
REQ-008 SHALL provide ports: s  output  WIDTH  quotient; r  output  WIDTH  remainder; div_by_zero  output  1  y was zero.

Function
REQ-009 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-010 SHALL accept on in_valid & in_ready edge, latching div_signed, |x|, |y|, quotient sign, remainder sign; x/y need not stay stable afterwards.
REQ-011 SHALL perform radix-2 restoring division, one quotient bit per cycle, MSB first, WIDTH+1-bit partial remainder.
REQ-012 SHALL spend exactly WIDTH cycles in CALC (macro off); out_valid rises WIDTH+1 edges after the accept edge.
REQ-013 SHALL hold s, r, div_by_zero registered and stable throughout DONE; leave DONE only on out_ready (or flush).
REQ-014 SHALL NOT accept a new request in the cycle DONE is left (no bypass); in_ready rises the cycle after.
REQ-015 SHALL sign results: s negated iff div_signed & (x[MSB]^y[MSB]); r negated iff div_signed & x[MSB]; unsigned mode uses raw values.
REQ-016 SHALL for y==0: s = all ones, r = x, div_by_zero=1; otherwise div_by_zero=0.
REQ-017 SHALL for signed x=most-negative, y=-1: s = x (most-negative), r = 0, no flag.
REQ-018 SHALL give flush priority over accept and out_ready; flush in any state returns to IDLE next edge, out_valid=0, result discarded.

Reset
REQ-019 SHALL on resetn=0 asynchronously force IDLE, in_ready=0 while reset asserted then 1, out_valid=0, s=0, r=0, div_by_zero=0, counter=0.
REQ-020 SHALL abandon any mid-operation state on reset; no result emitted for it.

Configuration
REQ-021 SHALL support macro DIV_ITER_EARLY_EXIT_EN: when defined, y==0 or |x|<|y| completes after 1 CALC cycle (out_valid 2 edges after accept) with results per REQ-015/016 (s=0, r=x for |x|<|y|).
REQ-022 SHALL without DIV_ITER_EARLY_EXIT_EN use fixed WIDTH-cycle latency for every operand, including y==0.

Structure
REQ-023 SHALL place FSM state enum, default WIDTH constant and counter width function ($clog2(WIDTH+1)) in shared package div_pkg.
REQ-024 SHALL isolate one combinational iteration (trial subtract, restore, quotient bit) in sub-module div_step, parameterised by WIDTH.

Verification
REQ-025 SHALL cover unsigned WIDTH=32: x=100, y=7 -> s=14, r=2, out_valid 33 edges after accept.
REQ-026 SHALL cover signed WIDTH=32: x=-7 (0xFFFFFFF9), y=2 -> s=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF); x=0x80000000, y=-1 -> s=0x80000000, r=0.
REQ-027 SHALL cover y=0, x=0x1234 -> s=0xFFFFFFFF, r=0x1234, div_by_zero=1; with macro, out_valid 2 edges after accept.
REQ-028 SHALL cover back-pressure: out_ready low 5 cycles -> s/r stable, in_ready=0; out_ready pulse -> IDLE next edge, new accept following edge.
REQ-029 SHALL cover flush at CALC cycle 10 with in_valid high -> no out_valid, no accept that edge, fresh request then completes correctly.
REQ-030 SHALL cover WIDTH=8 random signed/unsigned sweep vs. reference model, plus resetn pulsed mid-CALC -> out_valid=0, IDLE restored.
